// File: rtl/req_arbiter_16_pkg.sv
// req_arbiter_16_pkg: shared sizes, FSM encoding and popcount helper for the request arbiter
package req_arbiter_16_pkg;
  localparam int NUM_LINES = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LINES-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_LINES; i++) popcount += CNT_W'(v[i]);
  endfunction
endpackage

// File: rtl/req_arbiter_16_rr_pick16.sv
// rr_pick16: first set bit of pending at or above ptr, wrapping 15 -> 0
module rr_pick16
  import req_arbiter_16_pkg::*;
(
  input  logic [NUM_LINES-1:0] pending,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);
  logic [NUM_LINES-1:0] rot;
  logic [IDX_W-1:0] off;
  always_comb begin
    rot = NUM_LINES'({pending, pending} >> ptr);
    off = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
    idx = ptr + off;
    any = |pending;
  end
endmodule

// File: rtl/req_arbiter_16.sv
// req_arbiter_16: round-robin arbiter over a 16-line pending set with one-cycle bubble between grants
module req_arbiter_16
  import req_arbiter_16_pkg::*;
#(
  parameter logic [IDX_W-1:0] PTR_RESET = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] req_in,
  input  logic                 req_load,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  input  logic                 grant_ready,
  output logic [NUM_LINES-1:0] pending,
  output logic [CNT_W-1:0]     pending_cnt,
  output logic                 err_multi,
  input  logic                 err_clr
);
  state_t state, state_nx;
  logic [NUM_LINES-1:0] pending_nx, clr_mask, set_mask;
  logic [IDX_W-1:0] ptr, ptr_nx, idx_nx, pick_idx;
  logic pick_any, hs, go, multi, err_nx;
  rr_pick16 u_pick (
    .pending(pending),
    .ptr    (ptr),
    .idx    (pick_idx),
    .any    (pick_any)
  );
  assign grant_valid = (state == GRANT);
  assign pending_cnt = popcount(pending);
  // clear is applied before set so a same-edge reload of the granted line survives
  always_comb begin
    hs = grant_valid & grant_ready;
    go = (state == IDLE) & pick_any;
    multi = req_load & |(req_in & (req_in - 1'b1));
    clr_mask = {{(NUM_LINES-1){1'b0}}, hs} << grant_idx;
    set_mask = req_load ? req_in : '0;
    pending_nx = (pending & ~clr_mask) | set_mask;
    state_nx = go ? GRANT : hs ? IDLE : state;
    idx_nx = go ? pick_idx : grant_idx;
    ptr_nx = hs ? grant_idx + 1'b1 : ptr;
    err_nx = multi | (err_multi & ~err_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      ptr       <= PTR_RESET;
      grant_idx <= '0;
      err_multi <= 1'b0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      ptr       <= ptr_nx;
      grant_idx <= idx_nx;
      err_multi <= err_nx;
    end
  end
endmodule

// File: tb/tb_req_arbiter_16.sv
// tb_req_arbiter_16: directed and random stimulus against a round-robin reference model with a grant scoreboard
module tb_req_arbiter_16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] req_in = '0;
  logic req_load = 1'b0;
  logic grant_ready = 1'b0;
  logic err_clr = 1'b0;
  logic grant_valid;
  logic [3:0] grant_idx;
  logic [15:0] pending;
  logic [4:0] pending_cnt;
  logic err_multi;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  bit [15:0] m_pend;
  int m_ptr;
  bit m_gv;
  int m_idx;
  bit m_err;
  bit prev_gv = 1'b0;

  req_arbiter_16 #(.PTR_RESET(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_load(req_load),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_ready(grant_ready),
    .pending(pending), .pending_cnt(pending_cnt), .err_multi(err_multi), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_ptr = 0;
    m_gv = 1'b0;
    m_idx = 0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all();
    chk("grant_valid", grant_valid, m_gv);
    if (m_gv) chk("grant_idx_hold", grant_idx, m_idx);
    chk("pending", pending, m_pend);
    chk("pending_cnt", pending_cnt, $countones(m_pend));
    chk("err_multi", err_multi, m_err);
  endtask

  task automatic step(input logic ld, input logic [15:0] r, input logic rdy, input logic clr);
    bit [15:0] old_p;
    bit hs, found;
    req_load = ld;
    req_in = r;
    grant_ready = rdy;
    err_clr = clr;
    @(posedge clk);
    old_p = m_pend;
    hs = m_gv && rdy;
    if (hs) m_pend[m_idx] = 1'b0;
    if (ld) m_pend |= r;
    if (!m_gv && old_p != 0) begin
      found = 1'b0;
      for (int k = 0; k < 16; k++)
        if (!found && old_p[(m_ptr + k) % 16]) begin
          found = 1'b1;
          m_idx = (m_ptr + k) % 16;
        end
      m_gv = 1'b1;
      exp_q.push_back(m_idx);
    end else if (hs) begin
      m_gv = 1'b0;
      m_ptr = (m_idx + 1) % 16;
    end
    if (ld && $countones(r) > 1) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    #1;
    check_all();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, rdy, 1'b0);
  endtask

  // scoreboard: each new grant must match the next index the model predicted
  initial forever begin
    @(negedge clk);
    if (grant_valid && !prev_gv) begin
      if (exp_q.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
      else chk("grant_order", grant_idx, exp_q.pop_front());
    end
    prev_gv = grant_valid;
  end

  initial begin
    logic [15:0] r;
    model_reset();
    #12;
    check_all();
    chk("reset_idx", grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // single request on line 3
    step(1'b1, 16'h0008, 1'b1, 1'b0);
    chk("single_no_early_grant", grant_valid, 0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("single_idx", grant_idx, 3);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("single_cleared", pending, 0);
    // move ptr to 14, then wrap 15 -> 0
    step(1'b1, 16'h2000, 1'b1, 1'b0);
    run(2, 1'b1);
    step(1'b1, 16'h8000, 1'b1, 1'b0);
    step(1'b1, 16'h0001, 1'b1, 1'b0);
    chk("wrap_first", grant_idx, 15);
    run(5, 1'b1);
    // backpressure on line 5 while line 8 arrives
    step(1'b1, 16'h0020, 1'b0, 1'b0);
    step(1'b1, 16'h0100, 1'b0, 1'b0);
    run(3, 1'b0);
    chk("bp_idx_held", grant_idx, 5);
    chk("bp_cnt", pending_cnt, 2);
    run(6, 1'b1);
    // handshake and reload of the same line on one edge
    step(1'b1, 16'h0004, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0004, 1'b1, 1'b0);
    chk("set_wins", pending[2], 1);
    run(4, 1'b1);
    // multi-hot load and error clear
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    chk("multi_err", err_multi, 1);
    chk("multi_pending", pending, 16'h0011);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("multi_err_clr", err_multi, 0);
    step(1'b1, 16'h0300, 1'b0, 1'b1);
    chk("multi_set_wins_clr", err_multi, 1);
    run(10, 1'b1);
    // asynchronous reset in the middle of a grant
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre_reset_valid", grant_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_idx", grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(4, 1'b1);
    chk("no_grant_after_reset", grant_valid, 0);
    step(1'b1, 16'h0040, 1'b1, 1'b0);
    run(3, 1'b1);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2: r = 16'h0;
        3, 4: r = 16'($urandom);
        default: r = 16'h1 << $urandom_range(0, 15);
      endcase
      step(1'($urandom_range(0, 1)), r, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/req_arbiter_16.md
REQ_ARBITER_16 -- requirements
Module: req_arbiter_16

Interface
REQ-001 Parameter PTR_RESET, default 4'd0, meaning: round-robin search start index after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_in  input  16  one-hot request lines from the 4-to-16 decoder stage.
REQ-005 req_load  input  1  strobe: capture req_in into pending set this edge.
REQ-006 grant_valid  output  1  grant_idx holds a valid granted line.
REQ-007 grant_idx  output  4  index (0..15) of granted line.
REQ-008 grant_ready  input  1  consumer accepts grant when high with grant_valid.
REQ-009 pending  output  16  registered pending-request set.
REQ-010 pending_cnt  output  5  popcount of pending (0..16).
REQ-011 err_multi  output  1  sticky: a load carried more than one set bit.
REQ-012 err_clr  input  1  clears err_multi.

Function
REQ-013 On req_load, pending SHALL become pending | req_in at the same edge.
REQ-014 FSM SHALL have states IDLE and GRANT; grant_valid SHALL equal (state == GRANT), registered.
REQ-015 IDLE -> GRANT when pending != 0; grant_idx SHALL be the first set pending bit at or above ptr, searching upward with wrap 15 -> 0.
REQ-016 Latency: a bit first visible in pending after edge k SHALL produce grant_valid high after edge k+1.
REQ-017 In GRANT with grant_ready low, grant_idx and grant_valid SHALL hold stable.
REQ-018 Handshake (grant_valid & grant_ready): clear pending[grant_idx], set ptr = grant_idx + 1 mod 16, go to IDLE (one bubble cycle between grants).
REQ-019 Same-edge handshake clear and req_load set of the same bit SHALL leave the bit set (set wins).
REQ-020 Loads during GRANT SHALL update pending but SHALL NOT change grant_idx.
REQ-021 Reloading an already pending bit SHALL have no further effect (no counting).
REQ-022 req_load with popcount(req_in) > 1 SHALL still OR all bits in and SHALL set err_multi; req_in == 0 with req_load is legal and no-op.
REQ-023 err_clr SHALL clear err_multi unless a same-edge multi-hot load occurs (set wins).
REQ-024 pending_cnt SHALL be combinational popcount of registered pending, 5 bits, max 16.
REQ-025 grant_ready while grant_valid is low SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, pending 0, ptr PTR_RESET, grant_valid 0, grant_idx 0, err_multi 0, pending_cnt 0.
REQ-027 Reset asserted mid-GRANT SHALL drop grant_valid immediately and discard all pending requests.
REQ-028 After rst_n rises, first grant SHALL require a fresh req_load.

Structure
REQ-029 Shared package SHALL hold NUM_LINES = 16, IDX_W = 4, CNT_W = 5 and the FSM state encoding.
REQ-030 Round-robin search SHALL be a combinational sub-module rr_pick16 (inputs pending, ptr; outputs idx, any).
REQ-031 All outputs except pending_cnt SHALL be driven from registers.

Verification
REQ-032 Single request: load 16'h0008, ready high -> grant_valid high 2 edges after load, grant_idx 3, pending 0 after handshake, ptr 4.
REQ-033 Round-robin wrap: ptr 14, pending 16'h8001 (bits 15, 0) -> grants 15 then 0, one idle cycle between.
REQ-034 Backpressure: grant on idx 5, ready low 4 cycles while loading 16'h0100 -> idx 5 held stable, pending_cnt 2, then grants 5 then 8.
REQ-035 Set-wins: handshake on idx 2 same edge as load 16'h0004 -> pending[2] stays 1, next grant idx 2.
REQ-036 Multi-hot: load 16'h0011 -> err_multi 1, pending 16'h0011, pending_cnt 2; err_clr -> err_multi 0.
REQ-037 Reset mid-grant: pending 16'hFFFF, grant_valid high, assert rst_n low between edges -> all outputs 0 immediately, no grant after release until a new load.
